// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared types and constants for the clock-enable combiner
package clk_ctrl_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Largest supported wake / hold-off delay in cycles
  localparam int MAX_DLY = 255;

  // Counter width wide enough to hold the larger of the two delays
  function automatic int f_cnt_w(input int wake_cycles, input int hold_cycles);
    int m;
    m = 1;
    if (wake_cycles > m) m = wake_cycles;
    if (hold_cycles > m) m = hold_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_en_dly_cnt.sv
// rtl/clk_en_dly_cnt.sv - loadable down-counter shared by the wake and hold-off phases
module clk_en_dly_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; decrement saturates at zero so the counter never wraps
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_or_en_ctrl.sv
// rtl/clk_or_en_ctrl.sv - OR of masked channel requests driving a registered clock enable with wake and hold-off delays
module clk_or_en_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int NB_CH       = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NB_CH-1:0] i_req,
  output logic [NB_CH-1:0] o_ack,
  input  logic [NB_CH-1:0] i_mask,
  input  logic             i_force_on,
  output logic             o_clk_en,
  output logic             o_busy
);

  localparam int CNT_W = f_cnt_w(WAKE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  state_t           r_state;
  state_t           w_nxt;
  logic [NB_CH-1:0] w_req_eff;
  logic             w_active;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic             r_clk_en;
  logic             r_busy;
  logic [NB_CH-1:0] r_ack;

  assign w_req_eff = i_req & ~i_mask;
  assign w_active  = (|w_req_eff) | i_force_on;

  clk_en_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next state and counter control; zero-cycle delays skip WAKE/HOLD entirely
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active) begin
          if (WAKE_CYCLES == 0) begin
            w_nxt = RUN;
          end else begin
            w_nxt      = WAKE;
            w_load     = 1'b1;
            w_load_val = WAKE_LD;
          end
        end
      end
      WAKE: begin
        if (w_zero) w_nxt = RUN;
        else        w_dec = 1'b1;
      end
      RUN: begin
        if (!w_active) begin
          if (HOLD_CYCLES == 0) begin
            w_nxt = IDLE;
          end else begin
            w_nxt      = HOLD;
            w_load     = 1'b1;
            w_load_val = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (w_active)    w_nxt = RUN;
        else if (w_zero) w_nxt = IDLE;
        else             w_dec = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs registered from next state so enable and acks line up with the state they describe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_en <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_clk_en <= (w_nxt != IDLE);
      r_busy   <= (w_nxt != IDLE);
      r_ack    <= (w_nxt == RUN) ? w_req_eff : '0;
    end
  end

  assign o_clk_en = r_clk_en;
  assign o_busy   = r_busy;
  assign o_ack    = r_ack;

endmodule

// File: tb/tb_clk_or_en_ctrl.sv
// tb/tb_clk_or_en_ctrl.sv - table-driven bench for the clock-enable combiner
module tb_clk_or_en_ctrl;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       frc;
    logic [3:0] ack;
    logic       en;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, mask_a, ack_a;
  logic       force_a, en_a, busy_a;
  logic [3:0] req_b, mask_b, ack_b;
  logic       force_b, en_b, busy_b;

  int n_pass;
  int n_total;
  vec_t tbl[$];

  clk_or_en_ctrl #(.NB_CH(4), .WAKE_CYCLES(2), .HOLD_CYCLES(8)) u_dut_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req_a),
    .o_ack      (ack_a),
    .i_mask     (mask_a),
    .i_force_on (force_a),
    .o_clk_en   (en_a),
    .o_busy     (busy_a)
  );

  clk_or_en_ctrl #(.NB_CH(4), .WAKE_CYCLES(0), .HOLD_CYCLES(0)) u_dut_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req_b),
    .o_ack      (ack_b),
    .i_mask     (mask_b),
    .i_force_on (force_b),
    .o_clk_en   (en_b),
    .o_busy     (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] mask, input logic frc,
                     input logic [3:0] ack, input logic en, input logic busy);
    vec_t v;
    v.req = req; v.mask = mask; v.frc = frc;
    v.ack = ack; v.en = en; v.busy = busy;
    tbl.push_back(v);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    req_a = '0; mask_a = '0; force_a = 1'b0;
    req_b = '0; mask_b = '0; force_b = 1'b0;

    // wake: edge 0 enable, ack at edge 2
    add(4'b0001, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0001, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0001, 4'b0000, 0, 4'b0001, 1, 1);
    add(4'b0011, 4'b0000, 0, 4'b0011, 1, 1);
    // drop into HOLD, re-request three cycles in
    add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0100, 4'b0000, 0, 4'b0100, 1, 1);
    // full hold-off: enable drops 8 edges after ack drops
    add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    for (int i = 0; i < 7; i++) add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
    // request arriving exactly as HOLD expires returns to RUN
    add(4'b0010, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0010, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0010, 4'b0000, 0, 4'b0010, 1, 1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    for (int i = 0; i < 7; i++) add(4'b0000, 4'b0000, 0, 4'b0000, 1, 1);
    add(4'b0010, 4'b0000, 0, 4'b0010, 1, 1);
    // masking acked channels drops their acks next edge
    add(4'b0011, 4'b0000, 0, 4'b0011, 1, 1);
    add(4'b0011, 4'b0001, 0, 4'b0010, 1, 1);
    add(4'b0011, 4'b0011, 0, 4'b0000, 1, 1);
    for (int i = 0; i < 7; i++) add(4'b0011, 4'b0011, 0, 4'b0000, 1, 1);
    add(4'b0011, 4'b0011, 0, 4'b0000, 0, 0);
    // all masked: nothing wakes; force alone runs with no acks
    add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0);
    add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0);
    add(4'b1111, 4'b1111, 1, 4'b0000, 1, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 1, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 1, 1);
    add(4'b1111, 4'b0000, 0, 4'b1111, 1, 1);

    @(posedge clk); #1;
    chk("rst.ack", 32'(ack_a), 32'h0);
    chk("rst.en", 32'(en_a), 32'h0);
    chk("rst.busy", 32'(busy_a), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i].req; mask_a = tbl[i].mask; force_a = tbl[i].frc;
      @(posedge clk); #1;
      chk($sformatf("v%0d.ack", i), 32'(ack_a), 32'(tbl[i].ack));
      chk($sformatf("v%0d.en", i), 32'(en_a), 32'(tbl[i].en));
      chk($sformatf("v%0d.busy", i), 32'(busy_a), 32'(tbl[i].busy));
    end

    // async reset mid-RUN with all channels acked
    #3 rst = 1'b1;
    #1;
    chk("arst.ack", 32'(ack_a), 32'h0);
    chk("arst.en", 32'(en_a), 32'h0);
    chk("arst.busy", 32'(busy_a), 32'h0);
    req_a = '0; mask_a = '0; force_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // zero wake / zero hold: ack and enable move together
    req_b = 4'b0001;
    @(posedge clk); #1;
    chk("z.rise.ack", 32'(ack_b), 32'h1);
    chk("z.rise.en", 32'(en_b), 32'h1);
    req_b = 4'b0101;
    @(posedge clk); #1;
    chk("z.run.ack", 32'(ack_b), 32'h5);
    req_b = 4'b0000;
    @(posedge clk); #1;
    chk("z.fall.ack", 32'(ack_b), 32'h0);
    chk("z.fall.en", 32'(en_b), 32'h0);
    chk("z.fall.busy", 32'(busy_b), 32'h0);
    chk("a.idle.en", 32'(en_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
